// File: rtl/alu_uart_pkg.sv
// Shared types and defaults for the framed ALU/UART controller.
// Also holds the byte-count helper used to size the operand and result paths.
package alu_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOpcode,
    StOpa,
    StOpb,
    StExec,
    StTxSt,
    StTxRes,
    StTxWait
  } state_e;

  localparam logic [7:0] SYNC_DEF   = 8'hA5;
  localparam logic [7:0] ST_OK_DEF  = 8'h00;
  localparam logic [7:0] ST_TMO_DEF = 8'hEE;

  // Number of UART bytes needed to carry nb bits.
  function automatic int unsigned nbytes(input int unsigned nb, input int unsigned dbit);
    return (nb + dbit - 1) / dbit;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Generic inactivity timer: counts enabled cycles and flags expiry on the cycle
// that would reach TMO_CYC. A clear in the same cycle always wins over expiry.
module inactivity_timer #(
  parameter int unsigned TMO_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_uart_frame_ctrl.sv
// Frame controller between UART FIFOs and a combinational ALU: receives
// SYNC/opcode/A/B frames, returns a status byte plus the result, aborts on stall.
module alu_uart_frame_ctrl
  import alu_uart_pkg::*;
#(
  parameter int unsigned     DBIT    = 8,
  parameter int unsigned     NB_OP   = 6,
  parameter int unsigned     NB_AB   = 16,
  parameter logic [DBIT-1:0] SYNC    = SYNC_DEF,
  parameter logic [DBIT-1:0] ST_OK   = ST_OK_DEF,
  parameter logic [DBIT-1:0] ST_TMO  = ST_TMO_DEF,
  parameter int unsigned     TMO_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBIT-1:0]  r_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  output logic [DBIT-1:0]  w_data,
  output logic             wr_uart,
  input  logic             tx_done_tick,
  input  logic [NB_AB-1:0] result,
  output logic [NB_OP-1:0] op_code,
  output logic [NB_AB-1:0] data_a,
  output logic [NB_AB-1:0] data_b,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  localparam int unsigned NBYTES = nbytes(NB_AB, DBIT);
  localparam int unsigned PADW   = NBYTES * DBIT;
  localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_byte_cnt, w_byte_cnt_nxt;
  logic [CW-1:0]    r_tx_idx, w_tx_idx_nxt;
  logic             r_res_phase, w_res_phase_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic [NB_OP-1:0] r_op, w_op_nxt;
  logic [NB_AB-1:0] r_a, w_a_nxt;
  logic [NB_AB-1:0] r_b, w_b_nxt;
  logic [NB_AB-1:0] r_res, w_res_nxt;
  logic [DBIT-1:0]  r_wdata, w_wdata_nxt;
  logic             r_wr, w_wr_nxt;
  logic [7:0]       r_err, w_err_nxt;

  logic             w_rx_state;
  logic             w_tmo_en;
  logic             w_expire;
  logic             w_last_rx;
  logic [PADW-1:0]  w_a_pad, w_b_pad, w_res_pad;
  logic [CW-1:0]    w_idx;

  assign w_rx_state = (r_state == StIdle) || (r_state == StOpcode) ||
                      (r_state == StOpa)  || (r_state == StOpb);
  // Pop is gated by reset so nothing is consumed while the block is held.
  assign rd_uart    = reset_n && w_rx_state && !rx_empty;
  assign w_tmo_en   = (r_state == StOpcode || r_state == StOpa || r_state == StOpb) && rx_empty;
  assign w_last_rx  = (r_byte_cnt == LAST_BYTE);

  inactivity_timer #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (rd_uart),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_tx_idx_nxt    = r_tx_idx;
    w_res_phase_nxt = r_res_phase;
    w_tmo_nxt       = r_tmo;
    w_op_nxt        = r_op;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_res_nxt       = r_res;
    w_wdata_nxt     = r_wdata;
    w_wr_nxt        = 1'b0;
    w_err_nxt       = r_err;
    w_idx           = '0;
    w_a_pad              = '0;
    w_a_pad[NB_AB-1:0]   = r_a;
    w_b_pad              = '0;
    w_b_pad[NB_AB-1:0]   = r_b;
    w_res_pad            = '0;
    w_res_pad[NB_AB-1:0] = r_res;

    unique case (r_state)
      StIdle: begin
        if (rd_uart && (r_data == SYNC)) begin
          w_state_nxt    = StOpcode;
          w_byte_cnt_nxt = '0;
        end
      end
      StOpcode: begin
        if (rd_uart) begin
          w_op_nxt       = r_data[NB_OP-1:0];
          w_state_nxt    = StOpa;
          w_byte_cnt_nxt = '0;
        end
      end
      StOpa: begin
        if (rd_uart) begin
          w_a_pad[DBIT * 32'(r_byte_cnt) +: DBIT] = r_data;
          w_a_nxt = w_a_pad[NB_AB-1:0];
          if (w_last_rx) begin
            w_state_nxt    = StOpb;
            w_byte_cnt_nxt = '0;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + CW'(1);
          end
        end
      end
      StOpb: begin
        if (rd_uart) begin
          w_b_pad[DBIT * 32'(r_byte_cnt) +: DBIT] = r_data;
          w_b_nxt = w_b_pad[NB_AB-1:0];
          if (w_last_rx) begin
            w_state_nxt    = StExec;
            w_byte_cnt_nxt = '0;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + CW'(1);
          end
        end
      end
      StExec: begin
        w_res_nxt       = result;
        w_state_nxt     = StTxSt;
        w_wr_nxt        = 1'b1;
        w_wdata_nxt     = ST_OK;
        w_tmo_nxt       = 1'b0;
        w_res_phase_nxt = 1'b0;
        w_tx_idx_nxt    = '0;
      end
      StTxSt, StTxRes: begin
        w_state_nxt = StTxWait;
      end
      StTxWait: begin
        if (tx_done_tick) begin
          if (r_tmo || (r_res_phase && (r_tx_idx == LAST_BYTE))) begin
            w_state_nxt = StIdle;
          end else begin
            w_idx           = r_res_phase ? (r_tx_idx + CW'(1)) : '0;
            w_tx_idx_nxt    = w_idx;
            w_res_phase_nxt = 1'b1;
            w_wr_nxt        = 1'b1;
            w_wdata_nxt     = w_res_pad[DBIT * 32'(w_idx) +: DBIT];
            w_state_nxt     = StTxRes;
          end
        end
      end
    endcase

    // Expiry only fires with the FIFO empty, so it can never overlap a pop.
    if (w_expire) begin
      w_state_nxt    = StTxSt;
      w_byte_cnt_nxt = '0;
      w_wr_nxt       = 1'b1;
      w_wdata_nxt    = ST_TMO;
      w_tmo_nxt      = 1'b1;
      w_err_nxt      = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_byte_cnt  <= '0;
      r_tx_idx    <= '0;
      r_res_phase <= 1'b0;
      r_tmo       <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_tx_idx    <= w_tx_idx_nxt;
      r_res_phase <= w_res_phase_nxt;
      r_tmo       <= w_tmo_nxt;
      r_op        <= w_op_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_res       <= w_res_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wr        <= w_wr_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign op_code = r_op;
  assign data_a  = r_a;
  assign data_b  = r_b;
  assign w_data  = r_wdata;
  assign wr_uart = r_wr;
  assign busy    = (r_state != StIdle);
  assign err_cnt = r_err;

endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// Bench for alu_uart_frame_ctrl: a 16-bit and a 12-bit instance share one RX FIFO
// model and one TX responder, selected by sel; ALU model is A+B.
module tb_alu_uart_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sel = 1'b0;
  logic [7:0] r_data_m;
  logic       rx_empty_m;
  logic       tx_done_m;

  logic        rd16, wr16, busy16;
  logic [7:0]  wd16, err16;
  logic [5:0]  op16;
  logic [15:0] a16, b16, res16;
  logic        rd12, wr12, busy12;
  logic [7:0]  wd12, err12;
  logic [5:0]  op12;
  logic [11:0] a12, b12, res12;

  logic        rx_empty16, rx_empty12, tx_done16, tx_done12;
  logic        rd_sel, wr_sel, busy_sel;
  logic [7:0]  wd_sel;
  logic [5:0]  op_sel;
  logic [15:0] a_sel, b_sel;

  assign res16      = a16 + b16;
  assign res12      = a12 + b12;
  assign rx_empty16 = sel ? 1'b1 : rx_empty_m;
  assign rx_empty12 = sel ? rx_empty_m : 1'b1;
  assign tx_done16  = sel ? 1'b0 : tx_done_m;
  assign tx_done12  = sel ? tx_done_m : 1'b0;
  assign rd_sel     = sel ? rd12 : rd16;
  assign wr_sel     = sel ? wr12 : wr16;
  assign wd_sel     = sel ? wd12 : wd16;
  assign busy_sel   = sel ? busy12 : busy16;
  assign op_sel     = sel ? op12 : op16;
  assign a_sel      = sel ? {4'h0, a12} : a16;
  assign b_sel      = sel ? {4'h0, b12} : b16;

  alu_uart_frame_ctrl #(
    .DBIT (8), .NB_OP (6), .NB_AB (16), .SYNC (8'hA5), .ST_OK (8'h00), .ST_TMO (8'hEE),
    .TMO_CYC (50)
  ) dut16 (
    .clk (clk), .reset_n (rst_n), .r_data (r_data_m), .rx_empty (rx_empty16),
    .rd_uart (rd16), .w_data (wd16), .wr_uart (wr16), .tx_done_tick (tx_done16),
    .result (res16), .op_code (op16), .data_a (a16), .data_b (b16), .busy (busy16),
    .err_cnt (err16)
  );

  alu_uart_frame_ctrl #(
    .DBIT (8), .NB_OP (6), .NB_AB (12), .SYNC (8'hA5), .ST_OK (8'h00), .ST_TMO (8'hEE),
    .TMO_CYC (50)
  ) dut12 (
    .clk (clk), .reset_n (rst_n), .r_data (r_data_m), .rx_empty (rx_empty12),
    .rd_uart (rd12), .w_data (wd12), .wr_uart (wr12), .tx_done_tick (tx_done12),
    .result (res12), .op_code (op12), .data_a (a12), .data_b (b12), .busy (busy12),
    .err_cnt (err12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX FIFO and TX line model
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         last_pop = 0;
  bit         tx_busy  = 1'b0;
  int         dly      = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q.delete();
      tx_busy = 1'b0;
      dly = 0;
      tx_done_m  <= 1'b0;
      rx_empty_m <= 1'b1;
      r_data_m   <= 8'h00;
    end else begin
      tx_done_m <= 1'b0;
      if (rd_sel) begin
        if (rx_q.size() > 0) rx_q.delete(0);
        last_pop = cyc;
      end
      if (wr_sel) begin
        chk("tx_write_while_pending", {31'b0, tx_busy}, 32'd0);
        tx_log.push_back(wd_sel);
        tx_cyc.push_back(cyc);
        tx_busy = 1'b1;
        dly = 3;
      end else if (tx_busy) begin
        if (dly == 0) begin
          tx_done_m <= 1'b1;
          tx_busy = 1'b0;
        end else begin
          dly--;
        end
      end
      rx_empty_m <= (rx_q.size() == 0);
      r_data_m   <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  typedef struct {
    bit         sel;
    bit         pre;
    logic [7:0] op, a0, a1, b0, b1;
    logic [5:0] eop;
    logic [15:0] ea, eb;
    logic [7:0] t0, t1, t2;
  } vec_t;

  vec_t vecs[5];

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  function automatic logic [31:0] txb(input int k);
    return (tx_log.size() > k) ? {24'h0, tx_log[k]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] lat();
    return (tx_cyc.size() > 0) ? 32'(tx_cyc[0] - last_pop) : 32'hDEAD;
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    tx_cyc.delete();
  endtask

  task automatic wait_done(input int nb, input string tag);
    int t = 0;
    while ((tx_log.size() < nb || busy_sel || tx_busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_bounded_wait"}, {31'b0, t >= 400}, 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic push_frame(input vec_t v);
    push(8'hA5); push(v.op); push(v.a0); push(v.a1); push(v.b0); push(v.b1);
  endtask

  task automatic apply(input vec_t v, input string tag);
    bit busy_hi;
    sel = v.sel;
    clear_logs();
    if (v.pre) begin
      push(8'h00); push(8'hFF);
      busy_hi = 1'b0;
      repeat (4) begin
        @(negedge clk);
        busy_hi |= busy_sel;
      end
      chk({tag, "_discard_busy"}, {31'b0, busy_hi}, 32'd0);
      chk({tag, "_discard_popped"}, rx_q.size(), 32'd0);
    end
    push_frame(v);
    wait_done(3, tag);
    chk({tag, "_op_code"}, {26'h0, op_sel}, {26'h0, v.eop});
    chk({tag, "_data_a"}, {16'h0, a_sel}, {16'h0, v.ea});
    chk({tag, "_data_b"}, {16'h0, b_sel}, {16'h0, v.eb});
    chk({tag, "_tx_count"}, tx_log.size(), 32'd3);
    chk({tag, "_tx0"}, txb(0), {24'h0, v.t0});
    chk({tag, "_tx1"}, txb(1), {24'h0, v.t1});
    chk({tag, "_tx2"}, txb(2), {24'h0, v.t2});
    chk({tag, "_latency"}, lat(), 32'd2);
    chk({tag, "_busy_end"}, {31'b0, busy_sel}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vecs[0] = '{0, 0, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 6'h02, 16'h1234, 16'hABCD,
                8'h00, 8'h01, 8'hBE};
    vecs[1] = '{0, 1, 8'h3F, 8'hFF, 8'hFF, 8'h01, 8'h00, 6'h3F, 16'hFFFF, 16'h0001,
                8'h00, 8'h00, 8'h00};
    vecs[2] = '{0, 0, 8'hC5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 6'h05, 16'hA5A5, 16'h5A5A,
                8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{0, 0, 8'h11, 8'h80, 8'h00, 8'h80, 8'h00, 6'h11, 16'h0080, 16'h0080,
                8'h00, 8'h00, 8'h01};
    vecs[4] = '{1, 0, 8'h2A, 8'hBD, 8'h1A, 8'hFF, 8'hFF, 6'h2A, 16'h0ABD, 16'h0FFF,
                8'h00, 8'hBC, 8'h0A};

    repeat (3) @(negedge clk);
    chk("rst_wr_uart", {31'b0, wr16}, 32'd0);
    chk("rst_busy", {31'b0, busy16}, 32'd0);
    chk("rst_err_cnt", {24'h0, err16}, 32'd0);
    chk("rst_data_a", {16'h0, a16}, 32'd0);
    chk("rst_w_data", {24'h0, wd16}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Stalled frame: SYNC, opcode, one A byte, then nothing
    sel = 1'b0;
    clear_logs();
    push(8'hA5); push(8'h07); push(8'h34);
    wait_done(1, "tmo");
    chk("tmo_status", txb(0), 32'hEE);
    chk("tmo_no_result", tx_log.size(), 32'd1);
    chk("tmo_latency", lat(), 32'd51);
    chk("tmo_err_cnt", {24'h0, err16}, 32'd1);
    chk("tmo_idle", {31'b0, busy16}, 32'd0);
    chk("tmo_op_code", {26'h0, op16}, 32'h07);
    chk("tmo_partial_a", {16'h0, a16}, 32'h0034);
    chk("tmo_kept_b", {16'h0, b16}, 32'h0080);

    // Reset while the status byte is in flight
    clear_logs();
    push_frame(vecs[0]);
    t = 0;
    while (tx_log.size() < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_tx_reach", {31'b0, t >= 200}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_wr_uart", {31'b0, wr16}, 32'd0);
    chk("rst_tx_busy", {31'b0, busy16}, 32'd0);
    chk("rst_tx_err", {24'h0, err16}, 32'd0);
    chk("rst_tx_rd_uart", {31'b0, rd16}, 32'd0);
    // Reset while wr_uart is high
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    push_frame(vecs[3]);
    t = 0;
    while (!wr16 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_wr_reach", {31'b0, t >= 200}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", {31'b0, wr16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    apply(vecs[0], "post_rst");
    apply(vecs[4], "nb12");
    chk("nb12_err_cnt", {24'h0, err12}, 32'd0);

    // Saturation of the timeout counter
    sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      clear_logs();
      push(8'hA5);
      wait_done(1, "sat");
      if (i == 254) chk("sat_255", {24'h0, err16}, 32'd255);
    end
    chk("sat_stuck", {24'h0, err16}, 32'd255);
    chk("sat_last_status", txb(0), 32'hEE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
